// File: rtl/mesi_cache_ctrl.sv
// rtl/mesi_cache_ctrl.sv - MESI coherence controller for a private multi-line cache
module mesi_cache_ctrl #(
  parameter int INDEX_W = 2,
  localparam int NUM_LINES = 2 ** INDEX_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_valid,
  output logic                   cpu_ready,
  input  logic                   cpu_write,
  input  logic [INDEX_W-1:0]     cpu_index,
  output logic                   cpu_done,
  output logic                   cpu_hit,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  output logic [1:0]             bus_cmd,
  output logic [INDEX_W-1:0]     bus_index,
  input  logic                   bus_shared,
  input  logic                   snoop_valid,
  input  logic [1:0]             snoop_cmd,
  input  logic [INDEX_W-1:0]     snoop_index,
  output logic                   snoop_hit,
  output logic                   write_back,
  output logic [INDEX_W-1:0]     wb_index,
  output logic [2*NUM_LINES-1:0] line_state
);

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [1:0] CMD_RM  = 2'b00;
  localparam logic [1:0] CMD_WM  = 2'b01;
  localparam logic [1:0] CMD_INV = 2'b10;

  typedef enum logic [1:0] {IDLE, BUS_WAIT, RESP} state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] lines      [NUM_LINES];
  logic [1:0] lines_next [NUM_LINES];
  logic       hit_q;

  logic [1:0] cur_line;
  logic [1:0] snp_line;
  logic       accept;
  logic       need_bus;
  logic       snoop_act;

  assign cur_line  = lines[cpu_index];
  assign snp_line  = lines[snoop_index];
  // A snoop to the requested line stalls the core so classification sees the post-snoop state.
  assign cpu_ready = reset && (state == IDLE) && !(snoop_valid && (snoop_index == cpu_index));
  assign accept    = cpu_valid && cpu_ready;
  assign need_bus  = (cur_line == ST_I) || (cpu_write && (cur_line == ST_S));
  assign snoop_act = snoop_valid && (snoop_cmd != 2'b11);

  assign bus_req  = (state == BUS_WAIT);
  assign cpu_done = (state == RESP);
  assign cpu_hit  = (state == RESP) && hit_q;

  // Next FSM state: hits go straight to response, misses wait for the bus grant.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = need_bus ? BUS_WAIT : RESP;
      BUS_WAIT: if (bus_gnt) state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Next line states: snoop first, then silent E->M, then the grant update which overrides the snoop.
  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      lines_next[i] = lines[i];
      if (snoop_act && (snoop_index == INDEX_W'(i))) begin
        if (snoop_cmd == CMD_RM) begin
          if ((lines[i] == ST_M) || (lines[i] == ST_E)) lines_next[i] = ST_S;
        end else begin
          lines_next[i] = ST_I;
        end
      end
      if (accept && cpu_write && (cpu_index == INDEX_W'(i)) && (lines[i] == ST_E))
        lines_next[i] = ST_M;
      if ((state == BUS_WAIT) && bus_gnt && (bus_index == INDEX_W'(i)))
        lines_next[i] = (bus_cmd == CMD_RM) ? (bus_shared ? ST_S : ST_E) : ST_M;
    end
  end

  // Flatten line states for observation.
  always_comb begin
    line_state = '0;
    for (int i = 0; i < NUM_LINES; i++) line_state[2*i +: 2] = lines[i];
  end

  // State, line array and pending bus command registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hit_q     <= 1'b0;
      bus_cmd   <= CMD_RM;
      bus_index <= '0;
      for (int i = 0; i < NUM_LINES; i++) lines[i] <= ST_I;
    end else begin
      state <= state_next;
      for (int i = 0; i < NUM_LINES; i++) lines[i] <= lines_next[i];
      if (accept) begin
        hit_q <= (cur_line != ST_I);
        if (need_bus) begin
          bus_cmd   <= !cpu_write ? CMD_RM : ((cur_line == ST_I) ? CMD_WM : CMD_INV);
          bus_index <= cpu_index;
        end
      end else if ((state == BUS_WAIT) && !bus_gnt && (bus_cmd == CMD_INV) &&
                   (lines_next[bus_index] == ST_I)) begin
        // Our shared copy was taken away while waiting: we now need the data too.
        bus_cmd <= CMD_WM;
      end
    end
  end

  // Registered snoop response and write-back pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snoop_hit  <= 1'b0;
      write_back <= 1'b0;
      wb_index   <= '0;
    end else begin
      snoop_hit  <= snoop_act && (snp_line != ST_I);
      write_back <= snoop_act && (snp_line == ST_M);
      if (snoop_act && (snp_line == ST_M)) wb_index <= snoop_index;
    end
  end

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// tb/tb_mesi_cache_ctrl.sv - randomized self-checking bench for mesi_cache_ctrl
module tb_mesi_cache_ctrl;
  localparam int IW = 2;
  localparam int NL = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_valid = 1'b0;
  logic          cpu_ready;
  logic          cpu_write = 1'b0;
  logic [IW-1:0] cpu_index = '0;
  logic          cpu_done;
  logic          cpu_hit;
  logic          bus_req;
  logic          bus_gnt = 1'b0;
  logic [1:0]    bus_cmd;
  logic [IW-1:0] bus_index;
  logic          bus_shared = 1'b0;
  logic          snoop_valid = 1'b0;
  logic [1:0]    snoop_cmd = 2'b00;
  logic [IW-1:0] snoop_index = '0;
  logic          snoop_hit;
  logic          write_back;
  logic [IW-1:0] wb_index;
  logic [2*NL-1:0] line_state;

  int asserts = 0;
  int fails = 0;
  int model [NL];

  mesi_cache_ctrl #(.INDEX_W(IW)) dut (
    .clock(clock), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_write(cpu_write), .cpu_index(cpu_index),
    .cpu_done(cpu_done), .cpu_hit(cpu_hit),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_index(bus_index),
    .bus_shared(bus_shared),
    .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_index(snoop_index),
    .snoop_hit(snoop_hit), .write_back(write_back), .wb_index(wb_index),
    .line_state(line_state)
  );

  always #5 clock = ~clock;

  // States: 0=I 1=S 2=E 3=M
  function automatic logic [2*NL-1:0] flat();
    logic [2*NL-1:0] f;
    for (int i = 0; i < NL; i++) f[2*i +: 2] = 2'(model[i]);
    return f;
  endfunction

  function automatic int snoop_next(input int s, input int cmd);
    if (cmd == 0) return (s >= 2) ? 1 : s;
    if (cmd == 1 || cmd == 2) return 0;
    return s;
  endfunction

  // Processor request; optional snoop (scmd<4) in the first bus-wait cycle.
  task automatic cpu_op(input bit wr, input int idx, input int gdelay, input bit shared,
                        input int scmd, input int sidx);
    int st;
    bit exp_hit;
    bit bus;
    int ecmd;
    st = model[idx];
    exp_hit = (st != 0);
    bus = (st == 0) || (wr && st == 1);
    ecmd = !wr ? 0 : ((st == 0) ? 1 : 2);
    cpu_valid = 1'b1; cpu_write = wr; cpu_index = 2'(idx);
    #1;
    asserts++; if (cpu_ready !== 1'b1) begin fails++; $display("FAIL cpu_ready: got %b exp 1", cpu_ready); end
    @(negedge clock);
    cpu_valid = 1'b0;
    if (!bus) begin
      if (wr) model[idx] = 3;
      asserts++; if (cpu_done !== 1'b1) begin fails++; $display("FAIL hit_done: got %b exp 1", cpu_done); end
      asserts++; if (cpu_hit !== exp_hit) begin fails++; $display("FAIL hit_flag: got %b exp %b", cpu_hit, exp_hit); end
      asserts++; if (bus_req !== 1'b0) begin fails++; $display("FAIL hit_no_bus: got %b exp 0", bus_req); end
      asserts++; if (line_state !== flat()) begin fails++; $display("FAIL hit_lines: got %h exp %h", line_state, flat()); end
    end else begin
      for (int w = 0; w < gdelay; w++) begin
        asserts++; if (bus_req !== 1'b1) begin fails++; $display("FAIL wait_req: got %b exp 1", bus_req); end
        asserts++; if (bus_cmd !== 2'(ecmd)) begin fails++; $display("FAIL wait_cmd: got %0d exp %0d", bus_cmd, ecmd); end
        asserts++; if (bus_index !== 2'(idx)) begin fails++; $display("FAIL wait_index: got %0d exp %0d", bus_index, idx); end
        asserts++; if (cpu_done !== 1'b0) begin fails++; $display("FAIL wait_done: got %b exp 0", cpu_done); end
        if (w == 0 && scmd < 4) begin snoop_valid = 1'b1; snoop_cmd = 2'(scmd); snoop_index = 2'(sidx); end
        if (w == gdelay - 1) begin bus_gnt = 1'b1; bus_shared = shared; end
        @(negedge clock);
        snoop_valid = 1'b0; bus_gnt = 1'b0;
        if (w == 0 && scmd < 4) model[sidx] = snoop_next(model[sidx], scmd);
        if (w == gdelay - 1) model[idx] = (ecmd == 0) ? (shared ? 1 : 2) : 3;
        else if (ecmd == 2 && model[idx] == 0) ecmd = 1;
      end
      asserts++; if (bus_req !== 1'b0) begin fails++; $display("FAIL post_gnt_req: got %b exp 0", bus_req); end
      asserts++; if (cpu_done !== 1'b1) begin fails++; $display("FAIL miss_done: got %b exp 1", cpu_done); end
      asserts++; if (cpu_hit !== exp_hit) begin fails++; $display("FAIL miss_hit: got %b exp %b", cpu_hit, exp_hit); end
      asserts++; if (line_state !== flat()) begin fails++; $display("FAIL miss_lines: got %h exp %h", line_state, flat()); end
    end
    @(negedge clock);
    asserts++; if (cpu_done !== 1'b0) begin fails++; $display("FAIL done_pulse: got %b exp 0", cpu_done); end
  endtask

  task automatic snoop_op(input int cmd, input int idx);
    int es;
    bit eh;
    bit ewb;
    es = model[idx];
    eh = (cmd != 3) && (es != 0);
    ewb = (cmd != 3) && (es == 3);
    snoop_valid = 1'b1; snoop_cmd = 2'(cmd); snoop_index = 2'(idx);
    @(negedge clock);
    snoop_valid = 1'b0;
    model[idx] = snoop_next(es, cmd);
    asserts++; if (snoop_hit !== eh) begin fails++; $display("FAIL snoop_hit: got %b exp %b", snoop_hit, eh); end
    asserts++; if (write_back !== ewb) begin fails++; $display("FAIL write_back: got %b exp %b", write_back, ewb); end
    if (ewb) begin
      asserts++; if (wb_index !== 2'(idx)) begin fails++; $display("FAIL wb_index: got %0d exp %0d", wb_index, idx); end
    end
    asserts++; if (line_state !== flat()) begin fails++; $display("FAIL snoop_lines: got %h exp %h", line_state, flat()); end
    @(negedge clock);
    asserts++; if (write_back !== 1'b0) begin fails++; $display("FAIL wb_pulse: got %b exp 0", write_back); end
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_valid = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < NL; i++) model[i] = 0;
    asserts++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b exp 0", cpu_ready); end
    asserts++; if ({cpu_done, cpu_hit, bus_req, snoop_hit, write_back} !== 5'b0) begin
      fails++; $display("FAIL rst_flags: got %b exp 00000", {cpu_done, cpu_hit, bus_req, snoop_hit, write_back}); end
    asserts++; if ({bus_cmd, bus_index, wb_index} !== 6'b0) begin
      fails++; $display("FAIL rst_regs: got %h exp 0", {bus_cmd, bus_index, wb_index}); end
    asserts++; if (line_state !== 8'h00) begin fails++; $display("FAIL rst_lines: got %h exp 00", line_state); end
    cpu_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read_miss();
    cpu_op(1'b0, 2, 3, 1'b0, 4, 0);
    asserts++; if (line_state[5:4] !== 2'b10) begin fails++; $display("FAIL read_miss_E: got %b exp 10", line_state[5:4]); end
  endtask

  task automatic test_write_e();
    cpu_op(1'b1, 2, 1, 1'b0, 4, 0);
    asserts++; if (line_state[5:4] !== 2'b11) begin fails++; $display("FAIL write_e_M: got %b exp 11", line_state[5:4]); end
  endtask

  task automatic test_snoop_rm();
    snoop_op(0, 2);
    asserts++; if (line_state[5:4] !== 2'b01) begin fails++; $display("FAIL snoop_rm_S: got %b exp 01", line_state[5:4]); end
  endtask

  task automatic test_upgrade();
    cpu_op(1'b1, 2, 3, 1'b0, 1, 2);
    asserts++; if (line_state[5:4] !== 2'b11) begin fails++; $display("FAIL upgrade_M: got %b exp 11", line_state[5:4]); end
  endtask

  task automatic test_snoop_block();
    cpu_valid = 1'b1; cpu_write = 1'b1; cpu_index = 2'd2;
    snoop_valid = 1'b1; snoop_cmd = 2'b00; snoop_index = 2'd2;
    #1;
    asserts++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL block_ready: got %b exp 0", cpu_ready); end
    @(negedge clock);
    cpu_valid = 1'b0; snoop_valid = 1'b0;
    model[2] = snoop_next(model[2], 0);
    asserts++; if ({bus_req, cpu_done} !== 2'b00) begin fails++; $display("FAIL block_idle: got %b exp 00", {bus_req, cpu_done}); end
    cpu_op(1'b1, 2, 2, 1'b0, 4, 0);
  endtask

  task automatic test_reset_mid();
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_index = 2'd3;
    @(negedge clock);
    cpu_valid = 1'b0;
    asserts++; if (bus_req !== 1'b1) begin fails++; $display("FAIL mid_req: got %b exp 1", bus_req); end
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < NL; i++) model[i] = 0;
    asserts++; if (bus_req !== 1'b0) begin fails++; $display("FAIL mid_req_drop: got %b exp 0", bus_req); end
    asserts++; if (line_state !== flat()) begin fails++; $display("FAIL mid_lines: got %h exp %h", line_state, flat()); end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      asserts++; if ({cpu_done, bus_req} !== 2'b00) begin fails++; $display("FAIL mid_no_done: got %b exp 00", {cpu_done, bus_req}); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0)
        snoop_op(int'($urandom_range(0, 3)), int'($urandom_range(0, NL - 1)));
      else
        cpu_op(1'($urandom_range(0, 1)), int'($urandom_range(0, NL - 1)), int'($urandom_range(1, 4)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, NL - 1)));
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_read_miss();
    test_write_e();
    test_snoop_rm();
    test_upgrade();
    test_snoop_block();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
